// File: rtl/demux8_reg_bank.sv
// demux8_reg_bank: steers one byte stream into eight registered destinations.
// Three operations: single write, auto-incrementing burst write with wrap,
// and an 8-cycle sequential clear to CLEAR_VALUE.
// Optional feature macro: DEMUX8_WRITE_PROTECT_EN adds a per-register
// WriteProtect mask that suppresses writes and their strobes.
module demux8_reg_bank #(
   parameter int unsigned     WIDTH       = 8,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] InData,
   input  logic             Select0,
   input  logic             Select1,
   input  logic             Select2,
   input  logic             InValid,
   output logic             InReady,
   input  logic             Burst,
   input  logic [2:0]       BurstLen,
   input  logic             Clear,
`ifdef DEMUX8_WRITE_PROTECT_EN
   input  logic [7:0]       WriteProtect,
`endif
   output logic [WIDTH-1:0] OutA,
   output logic [WIDTH-1:0] OutB,
   output logic [WIDTH-1:0] OutC,
   output logic [WIDTH-1:0] OutD,
   output logic [WIDTH-1:0] OutE,
   output logic [WIDTH-1:0] OutF,
   output logic [WIDTH-1:0] OutG,
   output logic [WIDTH-1:0] OutH,
   output logic [7:0]       WriteStrobe,
   output logic             BurstActive,
   output logic             ClearBusy
);

   localparam int unsigned NREG  = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [IDX_W-1:0]   ptr, ptr_next;
   logic [IDX_W-1:0]   rem, rem_next;
   logic [WIDTH-1:0]   regs [NREG];
   logic [IDX_W-1:0]   sel;
   logic               accept;
   logic               wr_req;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic [WIDTH-1:0]   wr_data;
   logic [7:0]         wp;

   assign sel    = {Select2, Select1, Select0};
   assign accept = InValid && InReady;

`ifdef DEMUX8_WRITE_PROTECT_EN
   assign wp = WriteProtect;
`else
   assign wp = 8'h00;
`endif

   // A protected destination swallows the write; pointer bookkeeping is unaffected.
   assign wr_en = wr_req && !wp[wr_idx];

   // State, pointer and remaining-beat registers.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         rem   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         rem   <= rem_next;
      end
   end

   // Next-state logic and write request selection.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      rem_next   = rem;
      wr_req     = 1'b0;
      wr_idx     = ptr;
      wr_data    = InData;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               wr_req = 1'b1;
               wr_idx = sel;
               if (Burst && (BurstLen != '0)) begin
                  state_next = ST_BURST;
                  ptr_next   = IDX_W'(sel + IDX_W'(1));
                  rem_next   = BurstLen;
               end
            end
            // Clear wins over a burst start; a same-cycle beat is still written.
            if (Clear) begin
               state_next = ST_CLEAR;
               ptr_next   = '0;
               rem_next   = '0;
            end
         end
         ST_BURST: begin
            if (accept) begin
               wr_req   = 1'b1;
               wr_idx   = ptr;
               ptr_next = IDX_W'(ptr + IDX_W'(1));
               rem_next = IDX_W'(rem - IDX_W'(1));
               if (rem == IDX_W'(1)) begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_CLEAR: begin
            wr_req   = 1'b1;
            wr_idx   = ptr;
            wr_data  = CLEAR_VALUE;
            ptr_next = IDX_W'(ptr + IDX_W'(1));
            if (ptr == IDX_W'(NREG - 1)) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            ptr_next   = '0;
            rem_next   = '0;
         end
      endcase
   end

   // Destination register bank.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_idx] <= wr_data;
      end
   end

   // Registered handshake, status and one-hot write strobe.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         InReady     <= 1'b0;
         BurstActive <= 1'b0;
         ClearBusy   <= 1'b0;
         WriteStrobe <= '0;
      end else begin
         InReady     <= (state_next != ST_CLEAR);
         BurstActive <= (state_next == ST_BURST);
         ClearBusy   <= (state_next == ST_CLEAR);
         WriteStrobe <= wr_en ? (8'(1) << wr_idx) : 8'h00;
      end
   end

   assign OutA = regs[0];
   assign OutB = regs[1];
   assign OutC = regs[2];
   assign OutD = regs[3];
   assign OutE = regs[4];
   assign OutF = regs[5];
   assign OutG = regs[6];
   assign OutH = regs[7];

endmodule

// File: tb/tb_demux8_reg_bank.sv
// Scoreboard bench for demux8_reg_bank: stimulus pushes expected writes,
// a negedge monitor pops one entry per WriteStrobe pulse and compares.
module tb_demux8_reg_bank;

   logic       Clock;
   logic       Reset_n;
   logic [7:0] InData;
   logic       Select0, Select1, Select2;
   logic       InValid;
   logic       InReady;
   logic       Burst;
   logic [2:0] BurstLen;
   logic       Clear;
`ifdef DEMUX8_WRITE_PROTECT_EN
   logic [7:0] WriteProtect;
`endif
   logic [7:0] OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH;
   logic [7:0] WriteStrobe;
   logic       BurstActive;
   logic       ClearBusy;

   demux8_reg_bank #(.WIDTH(8), .CLEAR_VALUE(8'hA5)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .InData(InData),
      .Select0(Select0), .Select1(Select1), .Select2(Select2),
      .InValid(InValid), .InReady(InReady), .Burst(Burst),
      .BurstLen(BurstLen), .Clear(Clear),
`ifdef DEMUX8_WRITE_PROTECT_EN
      .WriteProtect(WriteProtect),
`endif
      .OutA(OutA), .OutB(OutB), .OutC(OutC), .OutD(OutD),
      .OutE(OutE), .OutF(OutF), .OutG(OutG), .OutH(OutH),
      .WriteStrobe(WriteStrobe), .BurstActive(BurstActive),
      .ClearBusy(ClearBusy)
   );

   typedef struct {
      logic [2:0] idx;
      logic [7:0] val;
   } exp_t;

   exp_t       sb [$];
   exp_t       mon_e;
   logic [7:0] outs [8];
   int         tests = 0;
   int         fails = 0;

   assign outs[0] = OutA;
   assign outs[1] = OutB;
   assign outs[2] = OutC;
   assign outs[3] = OutD;
   assign outs[4] = OutE;
   assign outs[5] = OutF;
   assign outs[6] = OutG;
   assign outs[7] = OutH;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] idx, input logic [7:0] val);
      exp_t e;
      e.idx = idx;
      e.val = val;
      sb.push_back(e);
   endtask

   // Present one beat for exactly one clock edge; called at posedge+1.
   task automatic send(input logic [7:0] d, input logic [2:0] s, input logic b,
                       input logic [2:0] l, input logic c);
      InData = d;
      {Select2, Select1, Select0} = s;
      Burst = b;
      BurstLen = l;
      Clear = c;
      InValid = 1'b1;
      @(posedge Clock); #1;
      InValid = 1'b0;
      Clear = 1'b0;
      Burst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // Monitor: every strobe pulse must match the oldest expected write.
   always @(negedge Clock) begin
      if (Reset_n && (WriteStrobe != 8'h00)) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got %02h expected none", WriteStrobe);
         end else begin
            mon_e = sb.pop_front();
            chk("strobe", WriteStrobe, 8'd1 << mon_e.idx);
            chk("wdata", outs[mon_e.idx], mon_e.val);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      InData = '0;
      {Select2, Select1, Select0} = 3'd0;
      InValid = 1'b0;
      Burst = 1'b0;
      BurstLen = '0;
      Clear = 1'b0;
`ifdef DEMUX8_WRITE_PROTECT_EN
      WriteProtect = 8'h00;
`endif
      // Reset state
      idle(2);
      chk("rst_outs", OutA | OutB | OutC | OutD | OutE | OutF | OutG | OutH, 8'h00);
      chk("rst_strobe", WriteStrobe, 8'h00);
      chk("rst_ready", 8'(InReady), 8'h00);
      chk("rst_flags", 8'({BurstActive, ClearBusy}), 8'h00);
      Reset_n = 1'b1;
      idle(1);
      chk("ready_after_rst", 8'(InReady), 8'h01);

      // Single write
      push(3'd3, 8'h5A);
      send(8'h5A, 3'd3, 1'b0, 3'd0, 1'b0);
      chk("single_outd", OutD, 8'h5A);
      chk("single_strobe", WriteStrobe, 8'h08);
      idle(1);
      chk("single_strobe_gone", WriteStrobe, 8'h00);
      chk("single_others", OutA | OutB | OutC | OutE | OutF | OutG | OutH, 8'h00);

      // Burst with wrap and one stall cycle
      push(3'd6, 8'h11);
      send(8'h11, 3'd6, 1'b1, 3'd3, 1'b0);
      chk("burst_active1", 8'(BurstActive), 8'h01);
      push(3'd7, 8'h22);
      send(8'h22, 3'd2, 1'b0, 3'd0, 1'b0);
      idle(1);
      chk("burst_stall_active", 8'(BurstActive), 8'h01);
      chk("burst_stall_strobe", WriteStrobe, 8'h00);
      push(3'd0, 8'h33);
      send(8'h33, 3'd5, 1'b1, 3'd7, 1'b1);
      chk("burst_active3", 8'(BurstActive), 8'h01);
      chk("burst_clear_ignored", 8'(ClearBusy), 8'h00);
      push(3'd1, 8'h44);
      send(8'h44, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("burst_done", 8'(BurstActive), 8'h00);
      chk("burst_outg", OutG, 8'h11);
      chk("burst_outh", OutH, 8'h22);
      chk("burst_outa", OutA, 8'h33);
      chk("burst_outb", OutB, 8'h44);
      chk("burst_outd_kept", OutD, 8'h5A);

      // Fill all, then sequential clear with InValid held high
      for (int i = 0; i < 8; i++) begin
         push(3'(i), 8'(8'h80 + i));
         send(8'(8'h80 + i), 3'(i), 1'b0, 3'd0, 1'b0);
      end
      chk("fill_outh", OutH, 8'h87);
      for (int i = 0; i < 8; i++) push(3'(i), 8'hA5);
      Clear = 1'b1;
      @(posedge Clock); #1;
      Clear = 1'b0;
      InData = 8'hEE;
      {Select2, Select1, Select0} = 3'd5;
      InValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("clr_busy", 8'(ClearBusy), 8'h01);
         chk("clr_ready", 8'(InReady), 8'h00);
         @(posedge Clock); #1;
      end
      InValid = 1'b0;
      chk("clr_done_busy", 8'(ClearBusy), 8'h00);
      chk("clr_done_ready", 8'(InReady), 8'h01);
      chk("clr_all_and", OutA & OutB & OutC & OutD & OutE & OutF & OutG & OutH, 8'hA5);
      chk("clr_all_or", OutA | OutB | OutC | OutD | OutE | OutF | OutG | OutH, 8'hA5);
      idle(1);

      // Single write together with Clear
      push(3'd2, 8'h77);
      for (int i = 0; i < 8; i++) push(3'(i), 8'hA5);
      send(8'h77, 3'd2, 1'b0, 3'd0, 1'b1);
      chk("wc_outc", OutC, 8'h77);
      chk("wc_busy", 8'(ClearBusy), 8'h01);
      idle(8);
      chk("wc_done", 8'(ClearBusy), 8'h00);
      chk("wc_outc_cleared", OutC, 8'hA5);

      // Reset mid-burst after 2 of 5 beats
      push(3'd4, 8'h01);
      send(8'h01, 3'd4, 1'b1, 3'd4, 1'b0);
      push(3'd5, 8'h02);
      send(8'h02, 3'd0, 1'b0, 3'd0, 1'b0);
      @(negedge Clock); #1;
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_outs", OutA | OutB | OutC | OutD | OutE | OutF | OutG | OutH, 8'h00);
      chk("mid_rst_burst", 8'(BurstActive), 8'h00);
      chk("mid_rst_strobe", WriteStrobe, 8'h00);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      idle(1);
      chk("mid_rst_ready", 8'(InReady), 8'h01);
      push(3'd3, 8'h99);
      send(8'h99, 3'd3, 1'b0, 3'd0, 1'b0);
      chk("post_rst_outd", OutD, 8'h99);
      chk("post_rst_outg", OutG, 8'h00);
      chk("post_rst_idle", 8'(BurstActive), 8'h00);

`ifdef DEMUX8_WRITE_PROTECT_EN
      // Protected middle register inside a burst
      WriteProtect = 8'h04;
      push(3'd1, 8'h10);
      send(8'h10, 3'd1, 1'b1, 3'd2, 1'b0);
      send(8'h20, 3'd0, 1'b0, 3'd0, 1'b0);
      push(3'd3, 8'h30);
      send(8'h30, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("wp_outb", OutB, 8'h10);
      chk("wp_outc", OutC, 8'h00);
      chk("wp_outd", OutD, 8'h30);
      chk("wp_idle", 8'(BurstActive), 8'h00);
      WriteProtect = 8'h00;
`endif

      idle(3);
      chk("sb_empty", 8'(sb.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
